// File: rtl/tx_frame_arbiter_pkg.sv
// Shared types and Ethernet defaults for the TX frame arbiter.
// Optional frame counters are enabled by the TX_ARB_FRAME_CNT_EN macro (see top).
package tx_frame_arbiter_pkg;

  localparam int ETH_MAX_FRAME = 1518;
  localparam int ETH_IFG       = 12;

  // Kept apart from the receiver's state enum so both can live in one scope.
  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_XFER,
    ARB_TRUNC,
    ARB_GAP
  } tx_arb_state_t;

  // Two-way round-robin pick; last_idx is the source granted most recently.
  function automatic logic [1:0] rr_pick(input logic [1:0] req, input logic last_idx);
    logic [1:0] gnt;
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last_idx ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
    return gnt;
  endfunction

endpackage

// File: rtl/tx_frame_arbiter_if.sv
// Byte-wide AXI-Stream link used for both frame sources and the MAC TX port.
interface tx_frame_arbiter_if;
  logic [7:0] tdata;
  logic       tvalid;
  logic       tlast;
  logic       tready;

  modport master (output tdata, output tvalid, output tlast, input  tready);
  modport slave  (input  tdata, input  tvalid, input  tlast, output tready);
endinterface

// File: rtl/tx_frame_arbiter_rr_arbiter2.sv
// Two-request round-robin picker with a registered "last granted" pointer.
module rr_arbiter2
  import tx_frame_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       upd,
  input  logic       upd_idx,
  output logic [1:0] gnt
);

  logic last_q;

  // Resetting to 1 makes source 0 win the first contested pick.
  always_ff @(posedge clk) begin
    if (!rst_n)   last_q <= 1'b1;
    else if (upd) last_q <= upd_idx;
  end

  assign gnt = rr_pick(req, last_q);

endmodule

// File: rtl/tx_frame_arbiter.sv
// Frame-atomic two-source arbiter in front of the MAC TX port, with IFG and length watchdog.
// Define TX_ARB_FRAME_CNT_EN to add per-source completed-frame counters.
module tx_frame_arbiter
  import tx_frame_arbiter_pkg::*;
#(
  parameter int IFG_CYCLES = ETH_IFG,
  parameter int MAX_LEN    = ETH_MAX_FRAME
) (
  input  logic               clk,
  input  logic               rst_n,
  tx_frame_arbiter_if.slave  s0,
  tx_frame_arbiter_if.slave  s1,
  tx_frame_arbiter_if.master m,
  output logic [1:0]         grant,
  output logic               busy,
  output logic               len_err
`ifdef TX_ARB_FRAME_CNT_EN
  ,
  output logic [15:0]        frame_cnt0,
  output logic [15:0]        frame_cnt1
`endif
);

  localparam int BW = $clog2(MAX_LEN + 1);
  localparam int GW = (IFG_CYCLES < 1) ? 1 : $clog2(IFG_CYCLES + 1);
  localparam logic [BW-1:0] BEAT_LAST = BW'(MAX_LEN - 1);
  localparam logic [GW-1:0] GAP_LOAD  = GW'(IFG_CYCLES);

  logic [1:0][7:0] src_data;
  logic [1:0]      src_valid, src_last, src_ready;

  assign src_data  = {s1.tdata,  s0.tdata};
  assign src_valid = {s1.tvalid, s0.tvalid};
  assign src_last  = {s1.tlast,  s0.tlast};
  assign s0.tready = src_ready[0];
  assign s1.tready = src_ready[1];

  tx_arb_state_t   state_q, state_d;
  logic [1:0]      grant_q, grant_d;
  logic [BW-1:0]   beat_q, beat_d;
  logic [GW-1:0]   gap_q, gap_d;
  logic            len_err_q, len_err_d;
  logic            frame_done;
  logic [1:0]      pick;

  logic            sel;
  logic            cur_valid, cur_last, at_max;
  logic [7:0]      cur_data;

  logic [7:0]      m_data;
  logic            m_valid, m_last;

  assign sel       = grant_q[1];
  assign cur_valid = src_valid[sel];
  assign cur_last  = src_last[sel];
  assign cur_data  = src_data[sel];
  assign at_max    = (beat_q == BEAT_LAST);

  rr_arbiter2 u_rr (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (src_valid),
    .upd     (frame_done),
    .upd_idx (sel),
    .gnt     (pick)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ARB_IDLE;
      grant_q   <= 2'b00;
      beat_q    <= '0;
      gap_q     <= '0;
      len_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      beat_q    <= beat_d;
      gap_q     <= gap_d;
      len_err_q <= len_err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    beat_d     = beat_q;
    gap_d      = gap_q;
    len_err_d  = 1'b0;
    frame_done = 1'b0;
    src_ready  = 2'b00;
    m_data     = 8'h00;
    m_valid    = 1'b0;
    m_last     = 1'b0;

    case (state_q)
      ARB_IDLE: begin
        if (|pick) begin
          grant_d = pick;
          state_d = ARB_XFER;
        end
      end

      ARB_XFER: begin
        m_data         = cur_data;
        m_valid        = cur_valid;
        m_last         = cur_last | at_max;
        src_ready[sel] = m.tready;
        if (cur_valid && m.tready) begin
          if (cur_last) begin
            frame_done = 1'b1;
          end else if (at_max) begin
            // MAC already saw tlast; swallow the rest of this frame.
            len_err_d = 1'b1;
            beat_d    = '0;
            state_d   = ARB_TRUNC;
          end else begin
            beat_d = beat_q + BW'(1);
          end
        end
      end

      ARB_TRUNC: begin
        src_ready[sel] = 1'b1;
        if (cur_valid && cur_last) frame_done = 1'b1;
      end

      ARB_GAP: begin
        // A zero IFG still spends one cycle here.
        if (gap_q <= GW'(1)) state_d = ARB_IDLE;
        else                 gap_d   = gap_q - GW'(1);
      end
    endcase

    if (frame_done) begin
      beat_d  = '0;
      grant_d = 2'b00;
      gap_d   = GAP_LOAD;
      state_d = ARB_GAP;
    end
  end

  assign m.tdata  = m_data;
  assign m.tvalid = m_valid;
  assign m.tlast  = m_last;
  assign grant    = grant_q;
  assign busy     = (state_q != ARB_IDLE);
  assign len_err  = len_err_q;

`ifdef TX_ARB_FRAME_CNT_EN
  logic [1:0][15:0] fcnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n)          fcnt_q      <= '0;
    else if (frame_done) fcnt_q[sel] <= fcnt_q[sel] + 16'd1;
  end

  assign frame_cnt0 = fcnt_q[0];
  assign frame_cnt1 = fcnt_q[1];
`endif

endmodule
